forward_converter_rns3_n25: RTL and testbench



---
 rtl/rns3_pkg.sv | 14 +
 rtl/mod_2n_plus1_fold.sv | 20 ++
 rtl/forward_converter_rns3_n25.sv | 110 +++++++++++
 tb/tb_forward_converter_rns3_n25.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rns3_pkg.sv
// Shared constants for the {2^N+1, 2^N, 2^N-1} RNS datapath.
package rns3_pkg;
    localparam int unsigned N  = 25;
    localparam int unsigned W1 = N + 1;
    localparam int unsigned W  = N;
    localparam int unsigned WX = 3 * N;

    localparam logic [W1-1:0] MOD1 = {1'b1, {(N-1){1'b0}}, 1'b1};
    localparam logic [W1-1:0] MOD2 = {1'b1, {N{1'b0}}};
    localparam logic [W-1:0]  MOD3 = {N{1'b1}};

    // Dynamic range 2^(3N) - 2^N: ones in the upper 2N bits, zeros below.
    localparam logic [WX-1:0] M = {{(2*N){1'b1}}, {N{1'b0}}};
endpackage

// File: rtl/mod_2n_plus1_fold.sv
// Single-step correction of a signed sum in -(2^N-1)..2^(N+1)-2 into 0..2^N.
module mod_2n_plus1_fold #(
    parameter int unsigned N = 25
) (
    input  logic signed [N+2:0] s,
    output logic [N:0]          x1
);
    localparam int unsigned  WO   = N + 1;
    localparam logic [N+2:0] MODU = {2'b00, 1'b1, {(N-1){1'b0}}, 1'b1};
    localparam logic signed [N+2:0] MODS = $signed(MODU);

    always_comb begin
        x1 = WO'(s);
        if (s < 0) begin
            x1 = WO'(s + MODS);
        end else if (s >= MODS) begin
            x1 = WO'(s - MODS);
        end
    end
endmodule

// File: rtl/forward_converter_rns3_n25.sv
// Two-stage binary-to-RNS forward converter with valid/ready backpressure.
// Optional out_oor flag (X >= M) is built when FWD_CONV_RANGE_CHECK_EN is defined.
module forward_converter_rns3_n25 #(
    parameter int unsigned N = rns3_pkg::N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3*N-1:0] in_x,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N:0]     out_x1,
    output logic [N-1:0]   out_x2,
    output logic [N-1:0]   out_x3
`ifdef FWD_CONV_RANGE_CHECK_EN
    ,
    output logic           out_oor
`endif
);
    import rns3_pkg::*;

    logic [N-1:0] b0, b1, b2;
    logic         adv1, adv2;
    logic         s1_valid, s2_valid;
    logic [N-1:0] s1_b0, s1_b1;
    logic [N:0]   s1_p;
    logic [N+1:0] s1_t;

    logic signed [N+2:0] s_val;
    logic [N:0]   x1_next;
    logic [N:0]   f1;
    logic [N-1:0] f2;
    logic [N-1:0] x3_next;

    assign b0 = in_x[N-1:0];
    assign b1 = in_x[2*N-1:N];
    assign b2 = in_x[3*N-1:2*N];

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_b0    <= '0;
            s1_b1    <= '0;
            s1_p     <= '0;
            s1_t     <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_b0 <= b0;
                s1_b1 <= b1;
                s1_p  <= {1'b0, b0} + {1'b0, b2};
                s1_t  <= {2'b00, b0} + {2'b00, b1} + {2'b00, b2};
            end
        end
    end

    assign s_val = $signed({2'b00, s1_p}) - $signed({3'b000, s1_b1});

    mod_2n_plus1_fold #(.N(N)) u_fold (
        .s  (s_val),
        .x1 (x1_next)
    );

    // End-around carry twice; the second fold cannot overflow N bits.
    always_comb begin
        f1      = {1'b0, s1_t[N-1:0]} + {{(N-1){1'b0}}, s1_t[N+1:N]};
        f2      = f1[N-1:0] + {{(N-1){1'b0}}, f1[N]};
        x3_next = (f2 == '1) ? '0 : f2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_x1   <= '0;
            out_x2   <= '0;
            out_x3   <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_x1 <= x1_next;
                out_x2 <= s1_b0;
                out_x3 <= x3_next;
            end
        end
    end

`ifdef FWD_CONV_RANGE_CHECK_EN
    logic s1_oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_oor  <= 1'b0;
            out_oor <= 1'b0;
        end else begin
            if (adv1 && in_valid) begin
                s1_oor <= &in_x[3*N-1:N];
            end
            if (adv2 && s1_valid) begin
                out_oor <= s1_oor;
            end
        end
    end
`endif
endmodule

// File: tb/tb_forward_converter_rns3_n25.sv
// Randomized bench for forward_converter_rns3_n25 against plain modular arithmetic.
module tb_forward_converter_rns3_n25;
    import rns3_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [WX-1:0] in_x = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W1-1:0] out_x1;
    logic [W-1:0]  out_x2;
    logic [W-1:0]  out_x3;
`ifdef FWD_CONV_RANGE_CHECK_EN
    logic          out_oor;
`endif

    forward_converter_rns3_n25 #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x1    (out_x1),
        .out_x2    (out_x2),
        .out_x3    (out_x3)
`ifdef FWD_CONV_RANGE_CHECK_EN
        ,
        .out_oor   (out_oor)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WX-1:0] x;
        int unsigned   cyc;
    } item_t;

    item_t       q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;

    function automatic logic [W1-1:0] ref_x1(input logic [WX-1:0] x);
        logic [WX-1:0] m;
        m = WX'(MOD1);
        return W1'(x % m);
    endfunction

    function automatic logic [W-1:0] ref_x2(input logic [WX-1:0] x);
        logic [WX-1:0] m;
        m = WX'(MOD2);
        return W'(x % m);
    endfunction

    function automatic logic [W-1:0] ref_x3(input logic [WX-1:0] x);
        logic [WX-1:0] m;
        m = WX'(MOD3);
        return W'(x % m);
    endfunction

    task automatic chk(input string name, input logic [WX-1:0] act, input logic [WX-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the queue of accepted operands.
    logic          hold_v = 1'b0;
    logic [W1-1:0] h1;
    logic [W-1:0]  h2, h3;

    always @(negedge clk) begin
        item_t it;
        logic  exp_valid;
        cyc++;
        if (!rst_n) begin
            q.delete();
            hold_v = 1'b0;
            chk("reset_out_valid", WX'(out_valid), '0);
            chk("reset_out_x1", WX'(out_x1), '0);
        end else begin
            exp_valid = (q.size() > 0) && (cyc - q[0].cyc >= 2);
            chk("out_valid", WX'(out_valid), WX'(exp_valid));
            chk("in_ready", WX'(in_ready), WX'((q.size() < 2) || out_ready));
            if (hold_v) begin
                chk("hold_valid", WX'(out_valid), WX'(1));
                chk("hold_x1", WX'(out_x1), WX'(h1));
                chk("hold_x2", WX'(out_x2), WX'(h2));
                chk("hold_x3", WX'(out_x3), WX'(h3));
            end
            hold_v = out_valid && !out_ready;
            h1 = out_x1;
            h2 = out_x2;
            h3 = out_x3;
            if (out_valid && out_ready && q.size() > 0) begin
                it = q.pop_front();
                chk("x1", WX'(out_x1), WX'(ref_x1(it.x)));
                chk("x2", WX'(out_x2), WX'(ref_x2(it.x)));
                chk("x3", WX'(out_x3), WX'(ref_x3(it.x)));
`ifdef FWD_CONV_RANGE_CHECK_EN
                chk("oor", WX'(out_oor), WX'(it.x >= M));
`endif
            end
            if (in_valid && in_ready) q.push_back('{x: in_x, cyc: cyc});
        end
    end

    task automatic send(input logic [WX-1:0] x);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_x = x;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 expected handshake within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [WX-1:0] rand_x();
        logic [WX-1:0] x;
        x = WX'({$urandom, $urandom, $urandom});
        if ($urandom_range(0, 7) == 0) x[WX-1:N] = '1;
        return x;
    endfunction

    initial begin
        logic [WX-1:0] xv;

        // Hand-computed residues pin the reference functions.
        xv = WX'(1) << N;
        chk("pin_x1_b1", WX'(ref_x1(xv)), WX'(33554432));
        chk("pin_x2_b1", WX'(ref_x2(xv)), WX'(0));
        chk("pin_x3_b1", WX'(ref_x3(xv)), WX'(1));
        xv = (WX'(1) << N) - WX'(1);
        chk("pin_x3_allones", WX'(ref_x3(xv)), WX'(0));
        chk("pin_x1_allones", WX'(ref_x1(xv)), WX'(33554431));
        xv = M - WX'(1);
        chk("pin_x1_mm1", WX'(ref_x1(xv)), WX'(33554432));
        chk("pin_x2_mm1", WX'(ref_x2(xv)), WX'(33554431));
        chk("pin_x3_mm1", WX'(ref_x3(xv)), WX'(33554430));
        chk("pin_x1_m", WX'(ref_x1(M)), WX'(0));
        chk("pin_x3_m", WX'(ref_x3(M)), WX'(0));

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Directed operands from the boundary list.
        send('0);
        send(WX'(1));
        send(WX'(1) << N);
        send((WX'(1) << N) - WX'(1));
        send(M - WX'(1));
        send(M);
        send('1);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: four back-to-back words against a stalled consumer.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(rand_x());
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(rand_x());
        send(rand_x());
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(rand_x());
        repeat (4) @(posedge clk);
        #1;

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_x      = rand_x();
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drained", WX'(q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
